// File: rtl/atm_disp_pkg.sv
// Shared types and constants for the ATM display formatter.
// Digit codes, FSM states and a compile-time power-of-ten helper.
package atm_disp_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t DIG_BLANK = 4'hA;
    localparam digit_t DIG_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FORMAT
    } state_t;

    function automatic int unsigned pow10(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD nibble.
// Adds 3 when the nibble is 5 or more so the next shift carries correctly.
module bcd_add3_digit
    import atm_disp_pkg::*;
(
    input  digit_t d,
    output digit_t q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/atm_bcd_display_formatter.sv
// Sequential binary-to-BCD formatter for the ATM seven-segment bank.
// Define ATM_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module atm_bcd_display_formatter
    import atm_disp_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   digits
);

    localparam int LW = (BIN_W > 32) ? BIN_W : 32;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [LW-1:0] LIMIT = LW'(pow10(DIGITS) - 1);
    localparam logic [CW-1:0] LAST  = CW'(BIN_W - 1);

    state_t             state;
    logic [BIN_W-1:0]   sr;
    logic [BW-1:0]      bcd;
    logic [BW-1:0]      bcd_adj;
    logic [BW-1:0]      shown;
    logic [CW-1:0]      cnt;
    logic               ovf_pend;
    logic [LW-1:0]      bin_ext;
    logic [BW+BIN_W-1:0] cat;

    assign bin_ext = LW'(bin_in);

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .d (bcd[4*g +: 4]),
            .q (bcd_adj[4*g +: 4])
        );
    end

    assign cat = {bcd_adj, sr} << 1;

`ifdef ATM_LEADING_ZERO_BLANK_EN
    logic lead;

    // Walk down from the top digit; units digit always stays visible.
    always_comb begin
        shown = bcd;
        lead  = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead = lead && (bcd[4*i +: 4] == 4'd0);
            if (lead) begin
                shown[4*i +: 4] = DIG_BLANK;
            end
        end
    end
`else
    assign shown = bcd;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            digits   <= {DIGITS{DIG_BLANK}};
            sr       <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sr       <= bin_in;
                        bcd      <= '0;
                        cnt      <= '0;
                        ovf_pend <= (bin_ext > LIMIT);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= cat[BW+BIN_W-1:BIN_W];
                    sr  <= cat[BIN_W-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FORMAT;
                    end
                end
                FORMAT: begin
                    if (ovf_pend) begin
                        digits   <= {DIGITS{DIG_ERR}};
                        overflow <= 1'b1;
                    end else begin
                        digits   <= shown;
                        overflow <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_bcd_display_formatter.sv
// Directed self-checking bench for atm_bcd_display_formatter.
// Expected digit codes follow ATM_LEADING_ZERO_BLANK_EN when defined.
module tb_atm_bcd_display_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] digits;

    int checks   = 0;
    int failures = 0;

`ifdef ATM_LEADING_ZERO_BLANK_EN
    localparam logic [15:0] EXP42  = 16'hAA42;
    localparam logic [15:0] EXP0   = 16'hAAA0;
    localparam logic [15:0] EXP7   = 16'hAAA7;
    localparam logic [15:0] EXP305 = 16'hA305;
`else
    localparam logic [15:0] EXP42  = 16'h0042;
    localparam logic [15:0] EXP0   = 16'h0000;
    localparam logic [15:0] EXP7   = 16'h0007;
    localparam logic [15:0] EXP305 = 16'h0305;
`endif

    always #5 clk = ~clk;

    atm_bcd_display_formatter #(
        .DIGITS (4),
        .BIN_W  (14)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .digits   (digits)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int ndone;
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        tick();
        tick();
        checks++;
        if (digits !== 16'hAAAA) begin
            failures++;
            $display("FAIL reset_digits got=%h exp=%h", digits, 16'hAAAA);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_overflow got=%b exp=0", overflow);
        end
        rst = 1'b0;
        tick();
        start  = 1'b1;
        bin_in = 14'd1234;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL abort_no_done got=%0d exp=0", ndone);
        end
        checks++;
        if (digits !== 16'hAAAA) begin
            failures++;
            $display("FAIL abort_digits got=%h exp=%h", digits, 16'hAAAA);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_convert(input logic [13:0] v, input logic [15:0] exp_d,
                                input logic exp_o);
        int          lat;
        logic [15:0] pre;
        bit          moved;
        start  = 1'b1;
        bin_in = v;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL conv_busy v=%0d got=%b exp=1", v, busy);
        end
        pre   = digits;
        moved = 1'b0;
        lat   = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (digits !== pre) moved = 1'b1;
        end
        checks++;
        if (lat != 15) begin
            failures++;
            $display("FAIL conv_latency v=%0d got=%0d exp=15", v, lat);
        end
        checks++;
        if (moved) begin
            failures++;
            $display("FAIL conv_stable v=%0d got=moved exp=steady", v);
        end
        checks++;
        if (digits !== exp_d) begin
            failures++;
            $display("FAIL conv_digits v=%0d got=%h exp=%h", v, digits, exp_d);
        end
        checks++;
        if (overflow !== exp_o) begin
            failures++;
            $display("FAIL conv_overflow v=%0d got=%b exp=%b", v, overflow, exp_o);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL conv_busy_fall v=%0d got=%b exp=0", v, busy);
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        int at;
        int lat;
        start  = 1'b1;
        bin_in = 14'd1234;
        tick();
        bin_in = 14'd5678;
        ndone  = 0;
        at     = -1;
        for (int k = 1; k <= 40; k++) begin
            start = (k == 3) || (k == 15);
            tick();
            if (done === 1'b1) begin
                ndone++;
                if (at < 0) at = k;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL ignore_done_count got=%0d exp=1", ndone);
        end
        checks++;
        if (at != 15) begin
            failures++;
            $display("FAIL ignore_done_edge got=%0d exp=15", at);
        end
        checks++;
        if (digits !== 16'h1234) begin
            failures++;
            $display("FAIL ignore_digits got=%h exp=%h", digits, 16'h1234);
        end
        start  = 1'b1;
        bin_in = 14'd1234;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done === 1'b1) break;
        end
        start  = 1'b1;
        bin_in = 14'd5678;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL after_done_accept got=%b exp=1", busy);
        end
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat != 15) begin
            failures++;
            $display("FAIL after_done_latency got=%0d exp=15", lat);
        end
        checks++;
        if (digits !== 16'h5678) begin
            failures++;
            $display("FAIL after_done_digits got=%h exp=%h", digits, 16'h5678);
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        int first;
        int last;
        int lowcnt;
        start  = 1'b1;
        bin_in = 14'd305;
        tick();
        ndone  = 0;
        first  = -1;
        last   = -1;
        lowcnt = 0;
        for (int k = 1; k <= 48; k++) begin
            tick();
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = k;
                last = k;
            end
            if (busy === 1'b0) lowcnt++;
        end
        start = 1'b0;
        checks++;
        if (ndone != 3) begin
            failures++;
            $display("FAIL b2b_done_count got=%0d exp=3", ndone);
        end
        checks++;
        if (first != 15 || last != 47) begin
            failures++;
            $display("FAIL b2b_done_edges got=%0d,%0d exp=15,47", first, last);
        end
        checks++;
        if (lowcnt != 3) begin
            failures++;
            $display("FAIL b2b_busy_low got=%0d exp=3", lowcnt);
        end
        checks++;
        if (digits !== EXP305) begin
            failures++;
            $display("FAIL b2b_digits got=%h exp=%h", digits, EXP305);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_overflow got=%b exp=0", overflow);
        end
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done === 1'b1) break;
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        test_reset();
        test_convert(14'd42, EXP42, 1'b0);
        test_convert(14'd9999, 16'h9999, 1'b0);
        test_convert(14'd0, EXP0, 1'b0);
        test_convert(14'd10000, 16'hEEEE, 1'b1);
        test_convert(14'd16383, 16'hEEEE, 1'b1);
        test_convert(14'd7, EXP7, 1'b0);
        test_ignore_start();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
